// File: rtl/fib_pkg.sv
// fib_pkg: shared types for the Fibonacci term generator.
package fib_pkg;
  localparam int FIB_SUM_W = 64;
  typedef enum logic {IDLE, EMIT} state_t;
  typedef struct packed {
    logic                 carry;
    logic [FIB_SUM_W-1:0] sum;
  } step_t;
endpackage

// File: rtl/fib_seq_gen_if.sv
// fib_if: control and term stream bundle for fib_seq_gen.
interface fib_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             continuous;
  logic [WIDTH-1:0] seed_a;
  logic [WIDTH-1:0] seed_b;
  logic [CNT_W-1:0] num_terms;
  logic             y_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] y_idx;
  logic             y_last;
  logic             overflow;
  logic             busy;
  modport master (
    output start, abort, continuous, seed_a, seed_b, num_terms, y_ready,
    input  y_valid, y, y_idx, y_last, overflow, busy
  );
  modport slave (
    input  start, abort, continuous, seed_a, seed_b, num_terms, y_ready,
    output y_valid, y, y_idx, y_last, overflow, busy
  );
endinterface

// File: rtl/fib_seq_gen_step.sv
// fib_step: WIDTH-bit add with carry out and optional saturation.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  step_t r;
  // WIDTH must stay below FIB_SUM_W so the carry lands in the upper bits
  always_comb begin
    r.sum   = FIB_SUM_W'(a) + FIB_SUM_W'(b);
    r.carry = |r.sum[FIB_SUM_W-1:WIDTH];
  end
  assign sum   = (SATURATE != 0 && r.carry) ? '1 : r.sum[WIDTH-1:0];
  assign carry = r.carry;
endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: programmable Fibonacci term source on a valid/ready stream.
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 4,
  parameter int SATURATE = 0
) (
  input logic  clk,
  input logic  rst_n,
  fib_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] cur, nxt, seed_a_q, seed_b_q;
  logic [WIDTH-1:0] cur_n, nxt_n, seed_a_n, seed_b_n, step_sum;
  logic [CNT_W-1:0] len_q, idx, len_n, idx_n;
  logic             ovf_cur, ovf_nxt, ovf_cur_n, ovf_nxt_n;
  logic             step_carry, last, xfer;

  fib_step #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_step (
    .a    (cur),
    .b    (nxt),
    .sum  (step_sum),
    .carry(step_carry)
  );

  assign last = idx == len_q - CNT_W'(1);
  assign xfer = state == EMIT && bus.y_ready;

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    nxt_n     = nxt;
    seed_a_n  = seed_a_q;
    seed_b_n  = seed_b_q;
    len_n     = len_q;
    idx_n     = idx;
    ovf_cur_n = ovf_cur;
    ovf_nxt_n = ovf_nxt;
    if (bus.abort) begin
      state_n   = IDLE;
      ovf_cur_n = 1'b0;
      ovf_nxt_n = 1'b0;
    end else if (state == IDLE && bus.start && bus.num_terms != '0) begin
      state_n   = EMIT;
      cur_n     = bus.seed_a;
      nxt_n     = bus.seed_b;
      seed_a_n  = bus.seed_a;
      seed_b_n  = bus.seed_b;
      len_n     = bus.num_terms;
      idx_n     = '0;
      ovf_cur_n = 1'b0;
      ovf_nxt_n = 1'b0;
    end else if (xfer && !last) begin
      cur_n     = nxt;
      nxt_n     = step_sum;
      idx_n     = idx + CNT_W'(1);
      ovf_cur_n = ovf_cur | ovf_nxt;
      ovf_nxt_n = ovf_nxt | step_carry;
    end else if (xfer && bus.continuous) begin
      // wrap straight into a fresh pass so the stream has no bubble
      cur_n     = seed_a_q;
      nxt_n     = seed_b_q;
      idx_n     = '0;
      ovf_cur_n = 1'b0;
      ovf_nxt_n = 1'b0;
    end else if (xfer) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur      <= '0;
      nxt      <= '0;
      seed_a_q <= '0;
      seed_b_q <= '0;
      len_q    <= '0;
      idx      <= '0;
      ovf_cur  <= 1'b0;
      ovf_nxt  <= 1'b0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      nxt      <= nxt_n;
      seed_a_q <= seed_a_n;
      seed_b_q <= seed_b_n;
      len_q    <= len_n;
      idx      <= idx_n;
      ovf_cur  <= ovf_cur_n;
      ovf_nxt  <= ovf_nxt_n;
    end
  end

  assign bus.busy     = state == EMIT;
  assign bus.y_valid  = state == EMIT;
  assign bus.y        = cur;
  assign bus.y_idx    = idx;
  assign bus.y_last   = state == EMIT && last;
  assign bus.overflow = ovf_cur;
endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: directed checks of fib_seq_gen in wrap and saturate builds.
module tb_fib_seq_gen;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort, continuous, y_ready;
  logic [7:0] seed_a, seed_b;
  logic [3:0] num_terms;
  logic [15:0] o0, o1;
  int tests, fails;
  int fib[8] = '{0, 1, 1, 2, 3, 5, 8, 13};

  fib_if #(.WIDTH(8), .CNT_W(4)) b0 ();
  fib_if #(.WIDTH(8), .CNT_W(4)) b1 ();

  fib_seq_gen #(.WIDTH(8), .CNT_W(4), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  fib_seq_gen #(.WIDTH(8), .CNT_W(4), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  assign b0.start = start;           assign b1.start = start;
  assign b0.abort = abort;           assign b1.abort = abort;
  assign b0.continuous = continuous; assign b1.continuous = continuous;
  assign b0.seed_a = seed_a;         assign b1.seed_a = seed_a;
  assign b0.seed_b = seed_b;         assign b1.seed_b = seed_b;
  assign b0.num_terms = num_terms;   assign b1.num_terms = num_terms;
  assign b0.y_ready = y_ready;       assign b1.y_ready = y_ready;

  assign o0 = {b0.y_valid, b0.busy, b0.y, b0.y_idx, b0.y_last, b0.overflow};
  assign o1 = {b1.y_valid, b1.busy, b1.y, b1.y_idx, b1.y_last, b1.overflow};

  always #5 clk = ~clk;

  task automatic kick(input logic [7:0] a, input logic [7:0] b, input logic [3:0] n);
    seed_a = a;
    seed_b = b;
    num_terms = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {start, abort, continuous} = '0;
    y_ready = 1'b1;
    seed_a = '0;
    seed_b = '0;
    num_terms = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (o0 !== 16'h0 || o1 !== 16'h0) begin
      fails++;
      $display("FAIL reset: got %h/%h want 0000/0000", o0, o1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (o0 !== 16'h0) begin
      fails++;
      $display("FAIL reset_release: got %h want 0000", o0);
    end
  endtask

  task automatic test_basic();
    logic [15:0] e;
    kick(8'd0, 8'd1, 4'd8);
    for (int i = 0; i < 8; i++) begin
      e = {2'b11, 8'(fib[i]), 4'(i), i == 7, 1'b0};
      tests++;
      if (o0 !== e) begin
        fails++;
        $display("FAIL basic term %0d: got %h want %h", i, o0, e);
      end
      @(negedge clk);
    end
    tests++;
    if (o0[15:14] !== 2'b00) begin
      fails++;
      $display("FAIL basic end: valid/busy got %b want 00", o0[15:14]);
    end
  endtask

  task automatic test_stall();
    logic [15:0] e;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k = 0;
    kick(8'd0, 8'd1, 4'd8);
    for (int c = 0; c < 40 && k < 8; c++) begin
      e = {2'b11, 8'(fib[k]), 4'(k), k == 7, 1'b0};
      tests++;
      if (o0 !== e) begin
        fails++;
        $display("FAIL stall cycle %0d: got %h want %h", c, o0, e);
      end
      y_ready = pat[c % 4];
      if (y_ready) k++;
      @(negedge clk);
    end
    tests++;
    if (k !== 8 || o0[15] !== 1'b0) begin
      fails++;
      $display("FAIL stall end: terms %0d valid %b want 8 0", k, o0[15]);
    end
    y_ready = 1'b1;
  endtask

  task automatic test_overflow();
    logic [15:0] e0, e1;
    int w[4] = '{89, 144, 233, 121};
    int s[4] = '{89, 144, 233, 255};
    kick(8'd89, 8'd144, 4'd4);
    for (int i = 0; i < 4; i++) begin
      e0 = {2'b11, 8'(w[i]), 4'(i), i == 3, i == 3};
      e1 = {2'b11, 8'(s[i]), 4'(i), i == 3, i == 3};
      tests++;
      if (o0 !== e0 || o1 !== e1) begin
        fails++;
        $display("FAIL overflow term %0d: got %h/%h want %h/%h", i, o0, o1, e0, e1);
      end
      @(negedge clk);
    end
    tests++;
    if (o1[15] !== 1'b0) begin
      fails++;
      $display("FAIL overflow end: valid got %b want 0", o1[15]);
    end
  endtask

  task automatic test_continuous();
    logic [15:0] e;
    continuous = 1'b1;
    kick(8'd0, 8'd1, 4'd8);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) begin
        e = {2'b11, 8'(fib[i]), 4'(i), i == 7, 1'b0};
        tests++;
        if (o0 !== e) begin
          fails++;
          $display("FAIL continuous pass %0d term %0d: got %h want %h", p, i, o0, e);
        end
        if (p == 1 && i == 0) continuous = 1'b0;
        @(negedge clk);
      end
    tests++;
    if (o0[15:14] !== 2'b00) begin
      fails++;
      $display("FAIL continuous stop: valid/busy got %b want 00", o0[15:14]);
    end
  endtask

  task automatic test_abort();
    kick(8'd89, 8'd144, 4'd8);
    repeat (3) @(negedge clk);
    tests++;
    if (o0 !== {2'b11, 8'd121, 4'd3, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL abort pre: got %h want %h", o0, {2'b11, 8'd121, 4'd3, 1'b0, 1'b1});
    end
    abort = 1'b1;
    start = 1'b1;
    seed_a = 8'd5;
    seed_b = 8'd7;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    tests++;
    if ({o0[15:14], o0[0]} !== 3'b000) begin
      fails++;
      $display("FAIL abort: valid/busy/ovf got %b want 000", {o0[15:14], o0[0]});
    end
    @(negedge clk);
    tests++;
    if (o0[15] !== 1'b0) begin
      fails++;
      $display("FAIL abort_start_ignored: valid got %b want 0", o0[15]);
    end
  endtask

  task automatic test_reset_mid();
    kick(8'd0, 8'd1, 4'd8);
    repeat (5) @(negedge clk);
    tests++;
    if (o0 !== {2'b11, 8'd5, 4'd5, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid pre: got %h want %h", o0, {2'b11, 8'd5, 4'd5, 1'b0, 1'b0});
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (o0 !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid async: got %h want 0000", o0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (o0 !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid after: got %h want 0000", o0);
    end
  endtask

  task automatic test_zero_terms();
    kick(8'd3, 8'd4, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (o0[15:14] !== 2'b00) begin
        fails++;
        $display("FAIL zero_terms cycle %0d: valid/busy got %b want 00", i, o0[15:14]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_in_emit();
    logic [15:0] e;
    kick(8'd0, 8'd1, 4'd8);
    for (int i = 0; i < 8; i++) begin
      e = {2'b11, 8'(fib[i]), 4'(i), i == 7, 1'b0};
      tests++;
      if (o0 !== e) begin
        fails++;
        $display("FAIL start_in_emit term %0d: got %h want %h", i, o0, e);
      end
      start = i == 2;
      seed_a = 8'd50;
      seed_b = 8'd60;
      num_terms = 4'd3;
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (o0[15] !== 1'b0) begin
      fails++;
      $display("FAIL start_in_emit end: valid got %b want 0", o0[15]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_zero_terms();
    test_start_in_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
